// File: rtl/dot_matrix_scanner_if.sv
// Interface between a frame producer and the dot-matrix scanner.
//   frame_in    : 64-bit pixel frame, bit 8*r+c is row r, column c (1 = lit)
//   frame_valid : frame_in is captured in this cycle
//   row         : row select pins (polarity set in the scanner)
//   col         : column pins for the selected row (polarity set in the scanner)
//   row_idx     : index of the row slot currently being scanned
//   frame_start : one-cycle pulse on the first blank cycle of row 0
// master = frame producer, slave = scanner.
interface dot_matrix_scanner_if;
    logic [63:0] frame_in;
    logic        frame_valid;
    logic [7:0]  row;
    logic [7:0]  col;
    logic [2:0]  row_idx;
    logic        frame_start;

    modport master (
        output frame_in,
        output frame_valid,
        input  row,
        input  col,
        input  row_idx,
        input  frame_start
    );

    modport slave (
        input  frame_in,
        input  frame_valid,
        output row,
        output col,
        output row_idx,
        output frame_start
    );
endinterface

// File: rtl/dot_matrix_scanner.sv
// Row-multiplexed driver for an 8x8 LED matrix.
// Each row slot is ROW_PERIOD cycles: BLANK_CYCLES with every pin inactive, then the
// row is driven with its column data. Incoming frames land in a shadow buffer and are
// only swapped into the displayed buffer at the frame boundary, so a frame is never torn.
// Ports:
//   clk : system clock
//   rst : synchronous active-high reset
//   bus : dot_matrix_scanner_if.slave (frame_in/frame_valid in; row/col/row_idx/frame_start out)
// All outputs are registered and computed from next-state values, so they always match
// the scan state of the cycle in which they are visible.
module dot_matrix_scanner #(
    parameter int unsigned ROW_PERIOD     = 6250,
    parameter int unsigned BLANK_CYCLES   = 16,
    parameter bit          ROW_ACTIVE_LOW = 1'b1,
    parameter bit          COL_ACTIVE_LOW = 1'b0
) (
    input logic                  clk,
    input logic                  rst,
    dot_matrix_scanner_if.slave  bus
);

    localparam int unsigned      CNT_W     = (ROW_PERIOD > 1) ? $clog2(ROW_PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(ROW_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
    localparam logic [7:0]       ROW_OFF   = ROW_ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [7:0]       COL_OFF   = COL_ACTIVE_LOW ? 8'hFF : 8'h00;

    typedef enum logic {StBlank, StDrive} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    // Low for exactly one cycle after reset; that cycle starts frame 0 without advancing.
    logic             run_q;
    logic [63:0]      shadow_q;
    logic             pending_q;
    logic [63:0]      active_q, active_d;
    logic             swap;
    logic [7:0]       row_sel;
    logic [7:0]       col_bits;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        swap     = 1'b0;
        active_d = active_q;

        if (!run_q) begin
            state_d = StBlank;
            cnt_d   = '0;
            idx_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
            state_d = StBlank;
            cnt_d   = '0;
            idx_d   = idx_q + 3'd1;
            swap    = (idx_q == 3'd7);
        end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = (cnt_d >= CNT_BLANK) ? StDrive : StBlank;
        end

        // A frame arriving on the boundary edge bypasses the shadow buffer.
        if (swap) begin
            if (bus.frame_valid) begin
                active_d = bus.frame_in;
            end else if (pending_q) begin
                active_d = shadow_q;
            end
        end

        row_sel  = 8'h01 << idx_d;
        col_bits = active_d[{idx_d, 3'b000} +: 8];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= StBlank;
            cnt_q           <= '0;
            idx_q           <= '0;
            run_q           <= 1'b0;
            shadow_q        <= '0;
            pending_q       <= 1'b0;
            active_q        <= '0;
            bus.row         <= ROW_OFF;
            bus.col         <= COL_OFF;
            bus.row_idx     <= '0;
            bus.frame_start <= 1'b0;
        end else begin
            run_q    <= 1'b1;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            active_q <= active_d;

            if (bus.frame_valid) begin
                shadow_q  <= bus.frame_in;
                pending_q <= ~swap;
            end else if (swap) begin
                pending_q <= 1'b0;
            end

            bus.row_idx     <= idx_d;
            bus.frame_start <= (idx_d == 3'd0) && (cnt_d == '0);

            if (state_d == StDrive) begin
                bus.row <= ROW_ACTIVE_LOW ? ~row_sel : row_sel;
                bus.col <= COL_ACTIVE_LOW ? ~col_bits : col_bits;
            end else begin
                bus.row <= ROW_OFF;
                bus.col <= COL_OFF;
            end
        end
    end

endmodule

// File: doc/dot_matrix_scanner.md
Name: dot_matrix_scanner

Overview:
- Downstream of DotMatrixDisplay. Consumes its 64-bit dot_matrix frame and drives the physical 8x8 LED matrix.
- Time-multiplexes one row at a time, with per-row blanking to suppress ghosting.
- Double-buffers frames so a new pattern only takes effect at a frame boundary. This prevents tearing.

Parameters:
- ROW_PERIOD, 6250, clk cycles per row slot (blank plus drive); 50 MHz / 8 rows / 6250 = 1 kHz frame rate.
- BLANK_CYCLES, 16, cycles at the start of each row slot with all outputs inactive. Legal range 1 <= BLANK_CYCLES < ROW_PERIOD.
- ROW_ACTIVE_LOW, 1, 1: a selected row pin is driven 0.
- COL_ACTIVE_LOW, 0, 1: a lit column pin is driven 0.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  synchronous, active-high reset.
- frame_in  in  64  pixel frame. Bit 8*r+c is row r, column c; 1 means lit.
- frame_valid  in  1  when high, frame_in is captured this cycle.
- row  out  8  row select. Bit r selects row r; polarity set by ROW_ACTIVE_LOW.
- col  out  8  column data for the selected row; polarity set by COL_ACTIVE_LOW.
- row_idx  out  3  index of the row slot currently being scanned.
- frame_start  out  1  one-cycle pulse on the first BLANK cycle of row 0.

Behaviour:
- Registers:
  - shadow[63:0] and pending flag (write side).
  - active[63:0] (displayed frame).
  - FSM {BLANK, DRIVE}.
  - slot counter cnt, 0..ROW_PERIOD-1.
  - row_idx.
- All outputs are registered. They change only on clk edges and are consistent with FSM state in the same cycle.
- Reset (rst=1 at an edge):
  - FSM=BLANK, cnt=0, row_idx=0.
  - active=0, shadow=0, pending=0.
  - row = all inactive (8'hFF if ROW_ACTIVE_LOW, else 8'h00); col = all inactive; frame_start=0.
  - Reset mid-scan takes effect on the next edge, regardless of FSM state.
- First cycle after rst release: BLANK, row_idx=0, frame_start=1.
- BLANK:
  - Lasts cnt = 0..BLANK_CYCLES-1.
  - row and col are all inactive.
  - Then go to DRIVE.
- DRIVE:
  - Lasts cnt = BLANK_CYCLES..ROW_PERIOD-1.
  - Only row bit row_idx is active.
  - col[c] is active iff active[8*row_idx+c]=1.
- Last DRIVE cycle (cnt=ROW_PERIOD-1):
  - Next state is BLANK, cnt=0, row_idx = row_idx+1 mod 8 (7 wraps to 0).
- Frame period is exactly 8*ROW_PERIOD cycles. frame_start pulses once per frame.
- Capture: frame_valid=1 means shadow<=frame_in and pending<=1. Multiple captures within one frame: the last one wins.
- Swap, on the edge from row 7's last DRIVE cycle into row 0 BLANK:
  - If pending: active<=shadow, pending<=0.
  - If frame_valid=1 on that same cycle: active<=frame_in directly, pending<=0. The incoming frame wins.
  - With no pending frame, active holds.
- Mid-frame captures never alter the rows still to be scanned in the current frame.
- Reset has priority over capture and swap.

Test Plan:
Benches use ROW_PERIOD=10, BLANK_CYCLES=2, ROW_ACTIVE_LOW=1, COL_ACTIVE_LOW=0.
- Reset: hold rst 3 cycles, frame_valid=1 -> row=8'hFF, col=8'h00, row_idx=0, frame_start=0 throughout; first cycle after release frame_start=1; capture ignored while in reset.
- Scan order: frame_valid pulse with 64'h8040201008040201 during frame 0; from frame 1 onward:
  - row r has 2 blank cycles (row=FF, col=00), then 8 drive cycles with row=~(8'h01<<r), col=8'h01<<r.
  - frame_start pulses every 80 cycles.
- Mid-frame update: active=64'h0, capture 64'hFFFF_FFFF_FFFF_FFFF while row_idx=3 -> rows 3..7 of the current frame drive col=00; every row of the next frame drives col=FF.
- Last-wins / simultaneous: capture A=64'h1 at row 2, then B=64'h2 on row 7's final DRIVE cycle -> next frame row 0 col=8'h02, and pending=0 afterwards.
- No update: no frame_valid for 3 frames -> identical col pattern each frame.
- Reset mid-scan: assert rst during row 5 DRIVE -> next cycle row=FF, col=00, row_idx=0; after release, col=00 in every row until a new capture swaps in.
